// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot engine control path: register map,
// reset viewport, AXI response codes and the start-request state type.
package mandelbrot_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Register word indexes (byte address >> 2)
    localparam int REG_CTRL      = 0;
    localparam int REG_STAT      = 1;
    localparam int REG_CRE_START = 2;
    localparam int REG_CIM_START = 3;
    localparam int REG_CRE_STEP  = 4;
    localparam int REG_CIM_STEP  = 5;
    localparam int REG_MAX_ITER  = 6;
    localparam int REG_ID        = 7;

    localparam logic [31:0] DEFAULT_CRE_START = 32'hE000_0000;
    localparam logic [31:0] DEFAULT_CIM_START = 32'hF319_999A;
    localparam logic [31:0] DEFAULT_CRE_STEP  = 32'h0026_6666;
    localparam logic [31:0] DEFAULT_CIM_STEP  = 32'h0026_6666;
    localparam int          DEFAULT_MAX_ITER  = 256;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } start_state_e;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_slave_if.sv
// AXI-Lite handshake engine: turns AW/W/B and AR/R channel traffic into a
// single-cycle register write strobe and a combinational register read port.
module axil_slave_if
    import mandelbrot_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic              wr_en_o,
    output logic [ADDR_W-3:0] wr_word_o,
    output logic [31:0]       wr_data_o,
    output logic [3:0]        wr_strb_o,
    input  logic              wr_err_i,
    output logic [ADDR_W-3:0] rd_word_o,
    input  logic [31:0]       rd_data_i,
    input  logic              rd_err_i
);

    logic              active_q;
    logic              aw_held_q;
    logic              w_held_q;
    logic [ADDR_W-3:0] awword_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic              rvalid_q;
    logic [1:0]        rresp_q;
    logic [31:0]       rdata_q;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

    // active_q keeps every ready low while reset is asserted
    assign s_awready = active_q && !aw_held_q && !bvalid_q;
    assign s_wready  = active_q && !w_held_q && !bvalid_q;
    assign s_arready = active_q && !rvalid_q;

    assign wr_en_o   = aw_held_q && w_held_q;
    assign wr_word_o = awword_q;
    assign wr_data_o = wdata_q;
    assign wr_strb_o = wstrb_q;
    assign rd_word_o = s_araddr[ADDR_W-1:2];

    assign s_bvalid = bvalid_q;
    assign s_bresp  = bresp_q;
    assign s_rvalid = rvalid_q;
    assign s_rresp  = rresp_q;
    assign s_rdata  = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awword_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            active_q <= 1'b1;
            if (s_awvalid && s_awready) begin
                aw_held_q <= 1'b1;
                awword_q  <= s_awaddr[ADDR_W-1:2];
            end
            if (s_wvalid && s_wready) begin
                w_held_q <= 1'b1;
                wdata_q  <= s_wdata;
                wstrb_q  <= s_wstrb;
            end
            // The register file commits on this edge; the response follows
            if (wr_en_o) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_err_i ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && s_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (s_arvalid && s_arready) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data_i;
            rresp_q  <= rd_err_i ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && s_rready) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/viewport_axil_regs.sv
// Viewport register file: staging registers written by the PS, committed as a
// set to the scheduler on every frame_start, plus start/auto-run sequencing.
module viewport_axil_regs
    import mandelbrot_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter int          ITER_W   = 16,
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] ID_VALUE = 32'h4D42_0001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    input  logic              frame_busy,
    input  logic              frame_done,
    output logic              frame_start,
    output logic [WIDTH-1:0]  c_re_start,
    output logic [WIDTH-1:0]  c_im_start,
    output logic [WIDTH-1:0]  c_re_step,
    output logic [WIDTH-1:0]  c_im_step,
    output logic [ITER_W-1:0] max_iter
);

    localparam int WORD_W = ADDR_W - 2;

    logic              wr_en;
    logic [WORD_W-1:0] wr_word;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic              wr_err;
    logic [WORD_W-1:0] rd_word;
    logic [31:0]       rd_data;
    logic              rd_err;

    logic              auto_run_q, auto_run_d;
    logic [WIDTH-1:0]  cre_start_q, cre_start_d;
    logic [WIDTH-1:0]  cim_start_q, cim_start_d;
    logic [WIDTH-1:0]  cre_step_q, cre_step_d;
    logic [WIDTH-1:0]  cim_step_q, cim_step_d;
    logic [ITER_W-1:0] max_iter_q, max_iter_d;

    logic [WIDTH-1:0]  commit_cre_start_q, commit_cim_start_q;
    logic [WIDTH-1:0]  commit_cre_step_q, commit_cim_step_q;
    logic [ITER_W-1:0] commit_max_iter_q;

    start_state_e      state_q, state_d;
    logic              boot_q;
    logic              frame_start_q;
    logic [15:0]       frame_cnt_q;
    logic              start_wr;
    logic              start_src;
    logic              issue;

    axil_slave_if #(.ADDR_W(ADDR_W)) u_axil (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .wr_en_o   (wr_en),
        .wr_word_o (wr_word),
        .wr_data_o (wr_data),
        .wr_strb_o (wr_strb),
        .wr_err_i  (wr_err),
        .rd_word_o (rd_word),
        .rd_data_i (rd_data),
        .rd_err_i  (rd_err)
    );

    assign frame_start = frame_start_q;
    assign c_re_start  = commit_cre_start_q;
    assign c_im_start  = commit_cim_start_q;
    assign c_re_step   = commit_cre_step_q;
    assign c_im_step   = commit_cim_step_q;
    assign max_iter    = commit_max_iter_q;

    always_comb begin
        auto_run_d  = auto_run_q;
        cre_start_d = cre_start_q;
        cim_start_d = cim_start_q;
        cre_step_d  = cre_step_q;
        cim_step_d  = cim_step_q;
        max_iter_d  = max_iter_q;
        start_wr    = 1'b0;
        wr_err      = 1'b0;
        case (wr_word)
            WORD_W'(REG_CTRL): begin
                if (wr_en && wr_strb[0]) begin
                    auto_run_d = wr_data[0];
                    start_wr   = wr_data[1];
                end
            end
            WORD_W'(REG_CRE_START):
                if (wr_en) cre_start_d = WIDTH'(apply_wstrb(32'(cre_start_q), wr_data, wr_strb));
            WORD_W'(REG_CIM_START):
                if (wr_en) cim_start_d = WIDTH'(apply_wstrb(32'(cim_start_q), wr_data, wr_strb));
            WORD_W'(REG_CRE_STEP):
                if (wr_en) cre_step_d = WIDTH'(apply_wstrb(32'(cre_step_q), wr_data, wr_strb));
            WORD_W'(REG_CIM_STEP):
                if (wr_en) cim_step_d = WIDTH'(apply_wstrb(32'(cim_step_q), wr_data, wr_strb));
            WORD_W'(REG_MAX_ITER):
                if (wr_en) max_iter_d = ITER_W'(apply_wstrb(32'(max_iter_q), wr_data, wr_strb));
            default: wr_err = 1'b1;
        endcase
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (rd_word)
            WORD_W'(REG_CTRL):      rd_data = {31'b0, auto_run_q};
            WORD_W'(REG_STAT):      rd_data = {frame_cnt_q, 14'b0, state_q == ST_PENDING, frame_busy};
            WORD_W'(REG_CRE_START): rd_data = 32'(cre_start_q);
            WORD_W'(REG_CIM_START): rd_data = 32'(cim_start_q);
            WORD_W'(REG_CRE_STEP):  rd_data = 32'(cre_step_q);
            WORD_W'(REG_CIM_STEP):  rd_data = 32'(cim_step_q);
            WORD_W'(REG_MAX_ITER):  rd_data = 32'(max_iter_q);
            WORD_W'(REG_ID):        rd_data = ID_VALUE;
            default:                rd_err  = 1'b1;
        endcase
    end

    // Any number of simultaneous requests collapse into one pending start
    assign start_src = (boot_q && auto_run_q) || start_wr || (frame_done && auto_run_q);

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE:
                if (start_src) state_d = ST_PENDING;
            ST_PENDING:
                if (!frame_busy && !frame_start_q) begin
                    issue   = 1'b1;
                    state_d = ST_IDLE;
                end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= ST_IDLE;
            boot_q             <= 1'b1;
            frame_start_q      <= 1'b0;
            frame_cnt_q        <= '0;
            auto_run_q         <= 1'b1;
            cre_start_q        <= WIDTH'(DEFAULT_CRE_START);
            cim_start_q        <= WIDTH'(DEFAULT_CIM_START);
            cre_step_q         <= WIDTH'(DEFAULT_CRE_STEP);
            cim_step_q         <= WIDTH'(DEFAULT_CIM_STEP);
            max_iter_q         <= ITER_W'(DEFAULT_MAX_ITER);
            commit_cre_start_q <= WIDTH'(DEFAULT_CRE_START);
            commit_cim_start_q <= WIDTH'(DEFAULT_CIM_START);
            commit_cre_step_q  <= WIDTH'(DEFAULT_CRE_STEP);
            commit_cim_step_q  <= WIDTH'(DEFAULT_CIM_STEP);
            commit_max_iter_q  <= ITER_W'(DEFAULT_MAX_ITER);
        end else begin
            state_q       <= state_d;
            boot_q        <= 1'b0;
            frame_start_q <= issue;
            if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
            auto_run_q  <= auto_run_d;
            cre_start_q <= cre_start_d;
            cim_start_q <= cim_start_d;
            cre_step_q  <= cre_step_d;
            cim_step_q  <= cim_step_d;
            max_iter_q  <= max_iter_d;
            // Commit takes the pre-write staging set so a frame never sees a torn update
            if (issue) begin
                commit_cre_start_q <= cre_start_q;
                commit_cim_start_q <= cim_start_q;
                commit_cre_step_q  <= cre_step_q;
                commit_cim_step_q  <= cim_step_q;
                commit_max_iter_q  <= max_iter_q;
            end
        end
    end

endmodule

// File: tb/tb_viewport_axil_regs.sv
// Directed bench for viewport_axil_regs: AXI-Lite register access, commit on
// frame start, start merging and frame counting, scoreboarded responses.
module tb_viewport_axil_regs;
    import mandelbrot_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [5:0]  s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic        frame_busy;
    logic        frame_done;
    logic        frame_start;
    logic [31:0] c_re_start;
    logic [31:0] c_im_start;
    logic [31:0] c_re_step;
    logic [31:0] c_im_step;
    logic [15:0] max_iter;

    int          total = 0;
    int          bad = 0;
    int          startCount = 0;
    logic [31:0] lastCre = '0;
    rd_exp_t     rdQ[$];
    logic [1:0]  bQ[$];

    viewport_axil_regs dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .frame_busy(frame_busy), .frame_done(frame_done), .frame_start(frame_start),
        .c_re_start(c_re_start), .c_im_start(c_im_start),
        .c_re_step(c_re_step), .c_im_step(c_im_step), .max_iter(max_iter)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && frame_start) begin
            startCount++;
            lastCre = c_re_start;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyWriteStimulus(input logic [5:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb, input int wLag, input int bHold,
                                      input logic [1:0] expResp);
        int  cyc;
        int  awCnt;
        int  wCnt;
        bit  awHs;
        bit  wHs;
        logic [1:0] exp;
        bQ.push_back(expResp);
        awCnt = 0;
        wCnt = 0;
        cyc = 0;
        s_awaddr = addr;
        s_awvalid = 1'b1;
        s_wdata = data;
        s_wstrb = strb;
        s_wvalid = (wLag == 0);
        while ((awCnt == 0 || wCnt == 0) && cyc < 40) begin
            awHs = s_awvalid && s_awready;
            wHs = s_wvalid && s_wready;
            tick(1);
            cyc++;
            if (awHs) begin awCnt++; s_awvalid = 1'b0; end
            if (wHs) begin wCnt++; s_wvalid = 1'b0; end
            if (wCnt == 0 && cyc >= wLag) s_wvalid = 1'b1;
            if (awCnt > 0 && wCnt == 0) checkOutput("aw_no_reaccept", s_awready, 0);
        end
        s_awvalid = 1'b0;
        s_wvalid = 1'b0;
        cyc = 0;
        while (!s_bvalid && cyc < 20) begin
            tick(1);
            cyc++;
        end
        checkOutput("bvalid_seen", s_bvalid, 1);
        tick(bHold);
        if (bHold > 0) begin
            checkOutput("bvalid_hold", s_bvalid, 1);
            checkOutput("no_accept_during_b", {s_awready, s_wready}, 0);
        end
        exp = bQ.pop_front();
        checkOutput("bresp", s_bresp, exp);
        s_bready = 1'b1;
        tick(1);
        s_bready = 1'b0;
        checkOutput("bvalid_clear", s_bvalid, 0);
    endtask

    task automatic applyReadStimulus(input logic [5:0] addr, input logic [31:0] expData,
                                     input logic [1:0] expResp);
        int      cyc;
        rd_exp_t exp;
        rdQ.push_back('{data: expData, resp: expResp});
        s_araddr = addr;
        s_arvalid = 1'b1;
        cyc = 0;
        while (!s_arready && cyc < 20) begin
            tick(1);
            cyc++;
        end
        tick(1);
        s_arvalid = 1'b0;
        cyc = 0;
        while (!s_rvalid && cyc < 20) begin
            tick(1);
            cyc++;
        end
        checkOutput("rvalid_seen", s_rvalid, 1);
        exp = rdQ.pop_front();
        checkOutput($sformatf("rdata@%h", addr), s_rdata, exp.data);
        checkOutput($sformatf("rresp@%h", addr), s_rresp, exp.resp);
        s_rready = 1'b1;
        tick(1);
        s_rready = 1'b0;
    endtask

    task automatic waitStart(input int base, input int budget);
        int cyc;
        cyc = 0;
        while (startCount == base && cyc < budget) begin
            tick(1);
            cyc++;
        end
        tick(3);
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        frame_busy = 1'b0;
        frame_done = 1'b0;
        tick(3);

        checkOutput("rst_readies", {s_awready, s_wready, s_arready}, 0);
        checkOutput("rst_valids", {s_bvalid, s_rvalid}, 0);
        checkOutput("rst_resps", {s_bresp, s_rresp}, 0);
        checkOutput("rst_frame_start", frame_start, 0);
        checkOutput("rst_c_re_start", c_re_start, 32'hE000_0000);
        checkOutput("rst_c_im_start", c_im_start, 32'hF319_999A);
        checkOutput("rst_c_re_step", c_re_step, 32'h0026_6666);
        checkOutput("rst_c_im_step", c_im_step, 32'h0026_6666);
        checkOutput("rst_max_iter", max_iter, 256);

        $display("[TB] boot start after reset release");
        rst_n = 1'b1;
        tick(1);
        checkOutput("boot_cycle1", frame_start, 0);
        tick(1);
        checkOutput("boot_cycle2", frame_start, 1);
        checkOutput("boot_commit_cre", c_re_start, 32'hE000_0000);
        tick(1);
        checkOutput("boot_cycle3", frame_start, 0);
        frame_busy = 1'b1;
        tick(4);
        checkOutput("boot_single", startCount, 1);

        $display("[TB] register reads");
        applyReadStimulus(6'h1C, 32'h4D42_0001, RESP_OKAY);
        applyReadStimulus(6'h00, 32'h0000_0001, RESP_OKAY);
        applyReadStimulus(6'h04, 32'h0000_0001, RESP_OKAY);

        $display("[TB] staging write during busy frame");
        applyWriteStimulus(6'h08, 32'hF000_0000, 4'hF, 0, 0, RESP_OKAY);
        checkOutput("staged_not_committed", c_re_start, 32'hE000_0000);
        applyReadStimulus(6'h08, 32'hF000_0000, RESP_OKAY);
        frame_done = 1'b1;
        tick(1);
        frame_done = 1'b0;
        applyReadStimulus(6'h04, 32'h0001_0003, RESP_OKAY);
        checkOutput("held_while_busy", startCount, 1);
        base = startCount;
        frame_busy = 1'b0;
        waitStart(base, 10);
        checkOutput("busy_drop_start", startCount, base + 1);
        checkOutput("commit_at_start", lastCre, 32'hF000_0000);
        frame_busy = 1'b1;

        $display("[TB] AW leads W, delayed bready");
        applyWriteStimulus(6'h0C, 32'h1234_5678, 4'hF, 3, 5, RESP_OKAY);
        applyReadStimulus(6'h0C, 32'h1234_5678, RESP_OKAY);

        $display("[TB] byte strobe and error responses");
        applyWriteStimulus(6'h18, 32'hFFFF_FFAB, 4'b0001, 0, 0, RESP_OKAY);
        applyReadStimulus(6'h18, 32'h0000_01AB, RESP_OKAY);
        applyReadStimulus(6'h24, 32'h0000_0000, RESP_SLVERR);
        applyWriteStimulus(6'h1C, 32'hDEAD_BEEF, 4'hF, 0, 0, RESP_SLVERR);
        applyReadStimulus(6'h1C, 32'h4D42_0001, RESP_OKAY);

        $display("[TB] START write coincident with frame_done");
        base = startCount;
        bQ.push_back(RESP_OKAY);
        s_awaddr = 6'h00; s_awvalid = 1'b1;
        s_wdata = 32'h0000_0003; s_wstrb = 4'hF; s_wvalid = 1'b1;
        tick(1);
        s_awvalid = 1'b0;
        s_wvalid = 1'b0;
        frame_done = 1'b1;
        tick(1);
        frame_done = 1'b0;
        checkOutput("merge_bvalid", s_bvalid, 1);
        checkOutput("merge_bresp", s_bresp, bQ.pop_front());
        s_bready = 1'b1;
        tick(1);
        s_bready = 1'b0;
        frame_busy = 1'b0;
        waitStart(base, 10);
        tick(5);
        checkOutput("merged_single_start", startCount, base + 1);
        applyReadStimulus(6'h04, 32'h0002_0000, RESP_OKAY);

        $display("[TB] clearing auto_run keeps a pending start");
        frame_busy = 1'b1;
        frame_done = 1'b1;
        tick(1);
        frame_done = 1'b0;
        applyWriteStimulus(6'h00, 32'h0000_0000, 4'hF, 0, 0, RESP_OKAY);
        applyReadStimulus(6'h04, 32'h0003_0003, RESP_OKAY);
        base = startCount;
        frame_busy = 1'b0;
        waitStart(base, 10);
        checkOutput("pending_survives_clear", startCount, base + 1);
        base = startCount;
        frame_done = 1'b1;
        tick(1);
        frame_done = 1'b0;
        tick(6);
        checkOutput("no_auto_start", startCount, base);

        $display("[TB] software START with auto_run off");
        applyWriteStimulus(6'h00, 32'h0000_0002, 4'hF, 0, 0, RESP_OKAY);
        waitStart(base, 10);
        checkOutput("sw_start", startCount, base + 1);
        applyReadStimulus(6'h00, 32'h0000_0000, RESP_OKAY);
        applyReadStimulus(6'h04, 32'h0004_0000, RESP_OKAY);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
